// File: rtl/shift_rows_stream.sv
// Byte-serial AES ShiftRows stage with a two-bank ping-pong state buffer.
// Optional out_last block delimiter is enabled by defining SHIFT_ROWS_LAST_EN.
module shift_rows_stream #(
    parameter bit INV    = 1'b0,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_byte
`ifdef SHIFT_ROWS_LAST_EN
    ,
    output logic              out_last
`endif
);

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [3:0]        wr_cnt_q,  wr_cnt_d;
    logic [3:0]        rd_cnt_q,  rd_cnt_d;
    logic [1:0]        full_q,    full_d;
    logic [DATA_W-1:0] bank_q [2][16];

    logic       in_fire, out_fire;
    logic [1:0] rd_row, rd_col, src_col;
    logic [3:0] src_idx;

    // Flags come straight from state, so valid/ready never see the other side's strobes.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];

    assign in_fire  = in_valid  && in_ready;
    assign out_fire = out_valid && out_ready;

    // Output index k = r + 4c reads source column (c +/- r) mod 4 of the same row.
    assign rd_row  = rd_cnt_q[1:0];
    assign rd_col  = rd_cnt_q[3:2];
    assign src_col = INV ? (rd_col - rd_row) : (rd_col + rd_row);
    assign src_idx = {src_col, rd_row};

    assign out_byte = out_valid ? bank_q[rd_bank_q][src_idx] : '0;

`ifdef SHIFT_ROWS_LAST_EN
    assign out_last = out_valid && (rd_cnt_q == 4'd15);
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;

        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // A completing write and a completing read always hit different banks.
        if (out_fire) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'd15) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
        end
    end

    // NOTE: the state buffer is not reset; full_q gates every read, so stale bytes never escape.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            bank_q[wr_bank_q][wr_cnt_q] <= in_byte;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: forward and inverse instances share one stimulus stream.
module tb_shift_rows_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_ready;
    logic       in_ready_f, out_valid_f, in_ready_i, out_valid_i;
    logic [7:0] out_byte_f, out_byte_i;
`ifdef SHIFT_ROWS_LAST_EN
    logic       out_last_f, out_last_i;
`endif

    int errors = 0;
    int checks = 0;

    // Output order as source byte indices; equals the output for an input stream 00..0f.
    logic [7:0] exp_fwd [16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                                 8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};
    logic [7:0] exp_inv [16] = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                                 8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
    logic [7:0] fips_in  [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                 8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    logic [7:0] fips_out [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

    shift_rows_stream #(.INV(1'b0), .DATA_W(8)) dut_fwd (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_f),
        .in_byte   (in_byte),
        .out_valid (out_valid_f),
        .out_ready (out_ready),
        .out_byte  (out_byte_f)
`ifdef SHIFT_ROWS_LAST_EN
        ,
        .out_last  (out_last_f)
`endif
    );

    shift_rows_stream #(.INV(1'b1), .DATA_W(8)) dut_inv (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_i),
        .in_byte   (in_byte),
        .out_valid (out_valid_i),
        .out_ready (out_ready),
        .out_byte  (out_byte_i)
`ifdef SHIFT_ROWS_LAST_EN
        ,
        .out_last  (out_last_i)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        cycle();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  {7'd0, in_ready_f},  8'd1);
        check("rst_out_valid", {7'd0, out_valid_f}, 8'd0);
        check("rst_out_byte",  out_byte_f,          8'h00);

        // Stream 00..0f into both variants
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'(i);
            check($sformatf("wr_out_valid[%0d]", i), {7'd0, out_valid_f}, 8'd0);
            check($sformatf("wr_in_ready[%0d]", i),  {7'd0, in_ready_f},  8'd1);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("fwd_valid[%0d]", k), {7'd0, out_valid_f}, 8'd1);
            check($sformatf("fwd_byte[%0d]", k),  out_byte_f,          exp_fwd[k]);
            check($sformatf("inv_valid[%0d]", k), {7'd0, out_valid_i}, 8'd1);
            check($sformatf("inv_byte[%0d]", k),  out_byte_i,          exp_inv[k]);
            cycle();
        end
        check("drain_out_valid", {7'd0, out_valid_f}, 8'd0);
        check("drain_in_ready",  {7'd0, in_ready_f},  8'd1);

        // FIPS-197 round 1 SubBytes output through forward ShiftRows
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_byte  = fips_in[i];
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("fips_byte[%0d]", k), out_byte_f, fips_out[k]);
            cycle();
        end
        check("fips_done", {7'd0, out_valid_f}, 8'd0);

        // Backpressure: blocks A=40.., B=50.., C=60.. with the reader stalled
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'h40 + 8'(i);
            check($sformatf("bp_in_ready[%0d]", i), {7'd0, in_ready_f}, 8'd1);
            cycle();
        end
        in_byte = 8'h60;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("bp_full_ready[%0d]", s), {7'd0, in_ready_f},  8'd0);
            check($sformatf("bp_full_valid[%0d]", s), {7'd0, out_valid_f}, 8'd1);
            check($sformatf("bp_stall_byte[%0d]", s), out_byte_f,          8'h40);
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("bp_a_byte[%0d]", k),  out_byte_f,         8'h40 + exp_fwd[k]);
            check($sformatf("bp_a_ready[%0d]", k), {7'd0, in_ready_f}, 8'd0);
            cycle();
        end
        // Block B drains while block C fills; both complete on the same edge.
        for (int k = 0; k < 16; k++) begin
            in_byte = 8'h60 + 8'(k);
            check($sformatf("bp_c_ready[%0d]", k), {7'd0, in_ready_f}, 8'd1);
            check($sformatf("bp_b_byte[%0d]", k),  out_byte_f,         8'h50 + exp_fwd[k]);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("bp_c_valid[%0d]", k), {7'd0, out_valid_f}, 8'd1);
            check($sformatf("bp_c_byte[%0d]", k),  out_byte_f,          8'h60 + exp_fwd[k]);
            cycle();
        end
        check("bp_done_valid", {7'd0, out_valid_f}, 8'd0);
        check("bp_done_ready", {7'd0, in_ready_f},  8'd1);

        // Back-to-back: two blocks, both handshakes held high
        do_reset();
        for (int t = 0; t < 48; t++) begin
            in_valid = (t < 32);
            in_byte  = 8'h80 + 8'(t);
            check($sformatf("b2b_ready[%0d]", t), {7'd0, in_ready_f}, 8'd1);
            if (t < 16) begin
                check($sformatf("b2b_idle[%0d]", t), {7'd0, out_valid_f}, 8'd0);
            end else begin
                check($sformatf("b2b_valid[%0d]", t), {7'd0, out_valid_f}, 8'd1);
                check($sformatf("b2b_byte[%0d]", t), out_byte_f,
                      ((t < 32) ? 8'h80 : 8'h90) + exp_fwd[(t - 16) % 16]);
            end
            cycle();
        end
        check("b2b_end_valid", {7'd0, out_valid_f}, 8'd0);

        // Reset after 7 input bytes discards the partial block
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'hc0 + 8'(i);
            cycle();
        end
        do_reset();
        check("mid_rst_in_ready",  {7'd0, in_ready_f},  8'd1);
        check("mid_rst_out_valid", {7'd0, out_valid_f}, 8'd0);
        check("mid_rst_out_byte",  out_byte_f,          8'h00);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'(i);
            check($sformatf("fresh_idle[%0d]", i), {7'd0, out_valid_f}, 8'd0);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("fresh_byte[%0d]", k), out_byte_f, exp_fwd[k]);
            check($sformatf("fresh_inv[%0d]", k),  out_byte_i, exp_inv[k]);
`ifdef SHIFT_ROWS_LAST_EN
            check($sformatf("fresh_last[%0d]", k), {7'd0, out_last_f}, (k == 15) ? 8'd1 : 8'd0);
`endif
            cycle();
        end
        check("fresh_done", {7'd0, out_valid_f}, 8'd0);
`ifdef SHIFT_ROWS_LAST_EN
        check("fresh_last_idle", {7'd0, out_last_f}, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
